rans_ctrl_regs: RTL and testbench
=================================

# rans_ctrl_regs

AXI-lite register front end for the multi-stream rANS encoder: it replaces the write-only frequency-table port with a full register map. Frequency-table entries are validated before reaching the engine, and a shadow copy of the table can be read back. Control and status registers provide restart, sticky error reporting and a symbol counter. The block sits between the PS AXI-lite master and the `rans_multi_stream` configuration inputs, and observes the symbol input stream.

## Interface
- `RESOLUTION`, 10: frequency precision in bits; `freq + cum_freq` must be ≤ 2^RESOLUTION.
- `SYMBOL_WIDTH`, 8: symbol width; the table holds 2^SYMBOL_WIDTH entries.
- `ADDR_WIDTH`, SYMBOL_WIDTH+3: byte-address width; addr[1:0] is ignored.
- `clk_i` in 1: the only clock; AXI-lite and engine share it.
- `rst_i` in 1: reset, synchronous and active-high.
- `s_awaddr`/`s_awvalid`/`s_awready`: in ADDR_WIDTH / in 1 / out 1; write-address channel.
- `s_wdata`/`s_wstrb`/`s_wvalid`/`s_wready`: in 32 / in 4 / in 1 / out 1; write-data channel.
- `s_bresp`/`s_bvalid`/`s_bready`: out 2 / out 1 / in 1; write-response channel.
- `s_araddr`/`s_arvalid`/`s_arready`: in ADDR_WIDTH / in 1 / out 1; read-address channel.
- `s_rdata`/`s_rresp`/`s_rvalid`/`s_rready`: out 32 / out 2 / out 1 / in 1; read-data channel.
- `eng_ready_i` in 1: the engine can accept a table write or a restart.
- `freq_wr_o` out 1: one-cycle table-write strobe.
- `symb_o` out SYMBOL_WIDTH, `freq_o` out RESOLUTION, `cum_freq_o` out RESOLUTION: table-write payload, valid while `freq_wr_o` is high.
- `restart_o` out 1: one-cycle engine restart strobe.
- `sym_valid_i`, `sym_ready_i` in 1 each: snoop of the engine symbol stream handshake.

## Operation
- Address map uses word index `a = addr[ADDR_WIDTH-1:2]`.
  - a < 2^S, FREQ[a] (RW): bits [R-1:0] = cum_freq, [2R-1:R] = freq.
  - a = 2^S, CTRL (WO, reads 0): bit0 = restart, bit1 = clear error; both are write-1 actions.
  - a = 2^S+1, STATUS (RO): bit0 = `eng_ready_i`, bit1 = err_sticky.
  - a = 2^S+2, SYMB_COUNT (RO, 32-bit).
  - a = 2^S+3, SCRATCH (RW, 32-bit).
  - Any other address → SLVERR (2'b10).
- Write path:
  - AW and W are captured independently into one holding register each; `s_awready = !aw_full`, `s_wready = !w_full`.
  - A write fires when aw_full, w_full, (`!s_bvalid` or `s_bready`) and `eng_ready_i` are all true.
  - `eng_ready_i` gates every fire, including writes to CTRL, SCRATCH and SLVERR addresses.
- Fire effects:
  - FREQ: write the shadow RAM, pulse `freq_wr_o` and drive the payload; BRESP OKAY.
  - CTRL: restart → pulse `restart_o` and clear SYMB_COUNT; clear error → err_sticky ← 0; BRESP OKAY.
  - SCRATCH: update the register; BRESP OKAY.
  - RO register or unmapped address: no effect; BRESP SLVERR.
- Validation: the write is rejected (no effect, SLVERR) if `wstrb != 4'hF`, or, for FREQ, if `freq + cum_freq > 2^R` (sum computed R+1 bits wide) or `wdata[31:2R] != 0`.
- Every SLVERR, read or write, sets err_sticky. Setting wins over a clear-error write in the same cycle.
- Read path:
  - One read outstanding at a time; `s_arready = !s_rvalid || s_rready`.
  - FREQ reads use a synchronous shadow read with unused upper bits as 0; register reads are muxed and registered.
- SYMB_COUNT increments when `sym_valid_i && sym_ready_i` and saturates at 0xFFFF_FFFF. A restart fire in the same cycle wins: the count becomes 0.

## Timing
- Reset values: `s_awready`, `s_wready` and `s_arready` are 1 in the first cycle after reset. `s_bvalid`, `s_rvalid`, `freq_wr_o` and `restart_o` are 0. `s_bresp`, `s_rresp`, `s_rdata`, `symb_o`, `freq_o`, `cum_freq_o`, SYMB_COUNT, SCRATCH and err_sticky are 0.
- The shadow RAM is not reset; reads of unwritten entries are undefined.
- Reset mid-transaction discards the holding registers and any pending B/R response.
- Write latency: if the later of the AW/W handshakes occurs in cycle t, the fire is in t+1, and `s_bvalid` plus the strobes are high in t+2.
  - Strobes last exactly 1 cycle.
  - `s_bvalid` stays high until `s_bready`.
- Write throughput: at most one write per 2 cycles.
- Read latency: AR handshake in cycle t → `s_rvalid` in t+1. `s_rdata` and `s_rresp` are held stable until `s_rready`.
- A same-edge FREQ read and write to the same entry return the old value (read-before-write).
- `eng_ready_i` low stalls the fire indefinitely; the holding registers stay full, so `awready`/`wready` stay low.

## Structure
- Package `rans_ctrl_pkg` holds:
  - register word offsets (relative to 2^SYMBOL_WIDTH)
  - `resp_t` with OKAY = 2'b00 and SLVERR = 2'b10
  - CTRL/STATUS bit indices
- Sub-module `rans_freq_shadow`: a 2^S × 2R single-write, single-read synchronous RAM, inferable as BRAM.

## Test plan
- After reset, write FREQ[0x41] = 0x0002_8010 (freq=0xA0, cum=0x10) → one cycle of `freq_wr_o` with symb=0x41, freq=0xA0, cum=0x10; BRESP OKAY; readback returns 0x0002_8010.
- W sent 3 cycles before AW → fire happens only once both are held; no strobe before AW; single BRESP OKAY.
- FREQ write freq=0x300, cum=0x200 (sum 0x500 > 0x400) → no `freq_wr_o`, SLVERR, STATUS=0b11; a CTRL write of 0x2 → STATUS=0b01.
- 5 symbol handshakes followed by a CTRL write of 0x1 coinciding with a 6th → `restart_o` pulses once and SYMB_COUNT reads 0.
- Hold `eng_ready_i` low for 10 cycles with a pending write, and `s_bready` low → no strobe and `awready`=0 throughout; a read of SCRATCH still completes; release → exactly one response.
- Back-to-back reads of FREQ, SCRATCH and unmapped 0x7FC with `s_rready` toggling → correct data in order, rdata stable while stalled, SLVERR on the last.

Source files
------------

// File: rtl/rans_ctrl_pkg.sv
// Shared types and register-map constants for the rANS control register front end.
package rans_ctrl_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Word offsets above the frequency table (table occupies word indices 0 .. 2^S-1).
    localparam int unsigned REG_CTRL       = 32'd0;
    localparam int unsigned REG_STATUS     = 32'd1;
    localparam int unsigned REG_SYMB_COUNT = 32'd2;
    localparam int unsigned REG_SCRATCH    = 32'd3;

    localparam int unsigned CTRL_RESTART_BIT     = 32'd0;
    localparam int unsigned CTRL_CLR_ERR_BIT     = 32'd1;
    localparam int unsigned STATUS_ENG_READY_BIT = 32'd0;
    localparam int unsigned STATUS_ERR_BIT       = 32'd1;

    typedef enum logic [2:0] {
        SEL_FREQ    = 3'd0,
        SEL_CTRL    = 3'd1,
        SEL_STATUS  = 3'd2,
        SEL_COUNT   = 3'd3,
        SEL_SCRATCH = 3'd4,
        SEL_NONE    = 3'd5
    } reg_sel_t;

endpackage

// File: rtl/rans_ctrl_regs_if.sv
// AXI-lite slave bundle for the rANS control registers.
interface rans_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 11
) ();
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/rans_freq_shadow.sv
// Shadow copy of the frequency table: one write port, one synchronous read port,
// read-before-write on a same-edge collision. Not reset so it maps onto block RAM.
module rans_freq_shadow #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rdata_q;

    // Read data only advances on a read request, so it holds while the response stalls.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/rans_ctrl_regs.sv
// AXI-lite register front end for the multi-stream rANS encoder: validated frequency
// table writes with shadow readback, control/status, symbol counter and scratch.
module rans_ctrl_regs
    import rans_ctrl_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int ADDR_WIDTH   = SYMBOL_WIDTH + 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    rans_ctrl_regs_if.slave         axi,
    input  logic                    eng_ready_i,
    output logic                    freq_wr_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    output logic [RESOLUTION-1:0]   freq_o,
    output logic [RESOLUTION-1:0]   cum_freq_o,
    output logic                    restart_o,
    input  logic                    sym_valid_i,
    input  logic                    sym_ready_i
);
    localparam int S  = SYMBOL_WIDTH;
    localparam int R  = RESOLUTION;
    localparam int IW = ADDR_WIDTH - 2;
    localparam int FW = 2 * RESOLUTION;

    function automatic reg_sel_t decode_sel(input logic [IW-1:0] idx);
        reg_sel_t sel;
        if (!idx[S]) begin
            sel = SEL_FREQ;
        end else begin
            case (idx[S-1:0])
                S'(REG_CTRL):       sel = SEL_CTRL;
                S'(REG_STATUS):     sel = SEL_STATUS;
                S'(REG_SYMB_COUNT): sel = SEL_COUNT;
                S'(REG_SCRATCH):    sel = SEL_SCRATCH;
                default:            sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // The sum is one bit wider than the fields so that exactly 2^R is still accepted.
    function automatic logic freq_word_ok(input logic [31:0] data);
        logic [R:0] sum;
        sum = {1'b0, data[FW-1:R]} + {1'b0, data[R-1:0]};
        return (sum <= {1'b1, {R{1'b0}}}) && (data[31:FW] == '0);
    endfunction

    logic          aw_full_q, aw_full_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic          w_full_q, w_full_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          freq_wr_q, freq_wr_d;
    logic [S-1:0]  symb_q, symb_d;
    logic [R-1:0]  freq_q, freq_d;
    logic [R-1:0]  cum_q, cum_d;
    logic          restart_q, restart_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   scratch_q, scratch_d;
    logic          err_q, err_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rd_freq_q, rd_freq_d;

    logic          aw_hs_s, w_hs_s, fire_s, wr_ok_s, arready_s, ar_hs_s, sym_hs_s;
    logic          freq_we_s, restart_fire_s, clr_err_s, ram_re_s, rd_slverr_s;
    reg_sel_t      wr_sel_s, rd_sel_s;
    logic [FW-1:0] ram_rdata_s;
    logic [31:0]   status_s;
    logic          addr_lsb_unused_s;

    assign aw_hs_s   = axi.s_awvalid && !aw_full_q;
    assign w_hs_s    = axi.s_wvalid && !w_full_q;
    assign fire_s    = aw_full_q && w_full_q && (!bvalid_q || axi.s_bready) && eng_ready_i;
    assign arready_s = !rvalid_q || axi.s_rready;
    assign ar_hs_s   = axi.s_arvalid && arready_s;
    assign sym_hs_s  = sym_valid_i && sym_ready_i;
    assign wr_sel_s  = decode_sel(aw_idx_q);
    assign rd_sel_s  = decode_sel(axi.s_araddr[ADDR_WIDTH-1:2]);

    assign freq_we_s      = fire_s && wr_ok_s && (wr_sel_s == SEL_FREQ);
    assign restart_fire_s = fire_s && wr_ok_s && (wr_sel_s == SEL_CTRL) && w_data_q[CTRL_RESTART_BIT];
    assign clr_err_s      = fire_s && wr_ok_s && (wr_sel_s == SEL_CTRL) && w_data_q[CTRL_CLR_ERR_BIT];
    assign ram_re_s       = ar_hs_s && (rd_sel_s == SEL_FREQ);
    assign rd_slverr_s    = ar_hs_s && (rd_sel_s == SEL_NONE);
    assign addr_lsb_unused_s = ^{axi.s_awaddr[1:0], axi.s_araddr[1:0]};

    // Write validation: partial strobes and read-only or unmapped targets are rejected.
    always_comb begin
        wr_ok_s = 1'b0;
        case (wr_sel_s)
            SEL_FREQ:    wr_ok_s = (w_strb_q == 4'hF) && freq_word_ok(w_data_q);
            SEL_CTRL:    wr_ok_s = (w_strb_q == 4'hF);
            SEL_SCRATCH: wr_ok_s = (w_strb_q == 4'hF);
            default:     wr_ok_s = 1'b0;
        endcase
    end

    // Write path: holding registers, response, strobes, and the state writes update.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        symb_d    = symb_q;
        freq_d    = freq_q;
        cum_d     = cum_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        err_d     = err_q;
        freq_wr_d = freq_we_s;
        restart_d = restart_fire_s;

        if (aw_hs_s) begin
            aw_full_d = 1'b1;
            aw_idx_d  = axi.s_awaddr[ADDR_WIDTH-1:2];
        end else if (fire_s) begin
            aw_full_d = 1'b0;
        end else begin
            aw_full_d = aw_full_q;
        end

        if (w_hs_s) begin
            w_full_d = 1'b1;
            w_data_d = axi.s_wdata;
            w_strb_d = axi.s_wstrb;
        end else if (fire_s) begin
            w_full_d = 1'b0;
        end else begin
            w_full_d = w_full_q;
        end

        if (fire_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (axi.s_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (freq_we_s) begin
            symb_d = aw_idx_q[S-1:0];
            freq_d = w_data_q[FW-1:R];
            cum_d  = w_data_q[R-1:0];
        end else begin
            symb_d = symb_q;
        end

        if (fire_s && wr_ok_s && (wr_sel_s == SEL_SCRATCH)) begin
            scratch_d = w_data_q;
        end else begin
            scratch_d = scratch_q;
        end

        if (restart_fire_s) begin
            count_d = 32'd0;
        end else if (sym_hs_s && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        // A new error in the same cycle beats a clear request.
        if ((fire_s && !wr_ok_s) || rd_slverr_s) begin
            err_d = 1'b1;
        end else if (clr_err_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Read path: capture response data at the AR handshake and hold it until RREADY.
    always_comb begin
        status_s                       = 32'd0;
        status_s[STATUS_ENG_READY_BIT] = eng_ready_i;
        status_s[STATUS_ERR_BIT]       = err_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_freq_d = rd_freq_q;

        if (ar_hs_s) begin
            rvalid_d  = 1'b1;
            rresp_d   = RESP_OKAY;
            rdata_d   = 32'd0;
            rd_freq_d = 1'b0;
            case (rd_sel_s)
                SEL_FREQ:    rd_freq_d = 1'b1;
                SEL_CTRL:    rdata_d   = 32'd0;
                SEL_STATUS:  rdata_d   = status_s;
                SEL_COUNT:   rdata_d   = count_q;
                SEL_SCRATCH: rdata_d   = scratch_q;
                default:     rresp_d   = RESP_SLVERR;
            endcase
        end else if (axi.s_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            freq_wr_q <= 1'b0;
            symb_q    <= '0;
            freq_q    <= '0;
            cum_q     <= '0;
            restart_q <= 1'b0;
            count_q   <= 32'd0;
            scratch_q <= 32'd0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'd0;
            rd_freq_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            freq_wr_q <= freq_wr_d;
            symb_q    <= symb_d;
            freq_q    <= freq_d;
            cum_q     <= cum_d;
            restart_q <= restart_d;
            count_q   <= count_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rd_freq_q <= rd_freq_d;
        end
    end

    rans_freq_shadow #(
        .ADDR_W (S),
        .DATA_W (FW)
    ) u_shadow (
        .clk_i   (clk_i),
        .we_i    (freq_we_s),
        .waddr_i (aw_idx_q[S-1:0]),
        .wdata_i (w_data_q[FW-1:0]),
        .re_i    (ram_re_s),
        .raddr_i (axi.s_araddr[S+1:2]),
        .rdata_o (ram_rdata_s)
    );

    assign axi.s_awready = !aw_full_q;
    assign axi.s_wready  = !w_full_q;
    assign axi.s_bvalid  = bvalid_q;
    assign axi.s_bresp   = bresp_q;
    assign axi.s_arready = arready_s;
    assign axi.s_rvalid  = rvalid_q;
    assign axi.s_rresp   = rresp_q;
    assign axi.s_rdata   = rd_freq_q ? {{(32 - FW){1'b0}}, ram_rdata_s} : rdata_q;

    assign freq_wr_o  = freq_wr_q;
    assign symb_o     = symb_q;
    assign freq_o     = freq_q;
    assign cum_freq_o = cum_q;
    assign restart_o  = restart_q;
endmodule

// File: tb/tb_rans_ctrl_regs.sv
// Scoreboard bench for rans_ctrl_regs: expected B/R responses and table strobes are
// queued when stimulus is issued and compared when the DUT presents them.
module tb_rans_ctrl_regs;
    import rans_ctrl_pkg::*;

    localparam int R  = 10;
    localparam int S  = 8;
    localparam int AW = 11;
    localparam logic [AW-1:0] A_CTRL    = 11'h400;
    localparam logic [AW-1:0] A_STATUS  = 11'h404;
    localparam logic [AW-1:0] A_COUNT   = 11'h408;
    localparam logic [AW-1:0] A_SCRATCH = 11'h40C;
    localparam logic [AW-1:0] A_BAD     = 11'h7FC;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    typedef struct packed {
        logic [S-1:0] symb;
        logic [R-1:0] freq;
        logic [R-1:0] cum;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic eng_ready, sym_valid, sym_ready;
    logic freq_wr, restart;
    logic [S-1:0] symb;
    logic [R-1:0] freq, cum;

    int checks_cnt  = 0;
    int errors_cnt  = 0;
    int restart_cnt = 0;
    int r0;
    logic rready_tog = 1'b0;
    logic stall_seen = 1'b0;
    logic [31:0] stall_data;
    logic [1:0] exp_b;
    rd_exp_t exp_r;
    wr_exp_t exp_f;

    logic [1:0] exp_b_q [$];
    rd_exp_t    exp_r_q [$];
    wr_exp_t    exp_f_q [$];

    rans_ctrl_regs_if #(.ADDR_WIDTH(AW)) axi ();

    rans_ctrl_regs #(
        .RESOLUTION   (R),
        .SYMBOL_WIDTH (S),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .axi         (axi),
        .eng_ready_i (eng_ready),
        .freq_wr_o   (freq_wr),
        .symb_o      (symb),
        .freq_o      (freq),
        .cum_freq_o  (cum),
        .restart_o   (restart),
        .sym_valid_i (sym_valid),
        .sym_ready_i (sym_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RREADY is either held high or toggled every cycle.
    always @(posedge clk) begin
        #1;
        if (rready_tog) axi.s_rready = ~axi.s_rready;
        else            axi.s_rready = 1'b1;
    end

    // Output monitor: pops the scoreboard on every DUT response or strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (axi.s_bvalid && axi.s_bready) begin
                if (exp_b_q.size() == 0) begin
                    check_val("b_unexpected", exp_b_q.size(), 1);
                end else begin
                    exp_b = exp_b_q.pop_front();
                    check_val("bresp", {30'd0, axi.s_bresp}, {30'd0, exp_b});
                end
            end
            if (axi.s_rvalid) begin
                if (stall_seen) check_val("rdata_stable", axi.s_rdata, stall_data);
                if (axi.s_rready) begin
                    stall_seen = 1'b0;
                    if (exp_r_q.size() == 0) begin
                        check_val("r_unexpected", exp_r_q.size(), 1);
                    end else begin
                        exp_r = exp_r_q.pop_front();
                        check_val("rdata", axi.s_rdata, exp_r.data);
                        check_val("rresp", {30'd0, axi.s_rresp}, {30'd0, exp_r.resp});
                    end
                end else begin
                    stall_seen = 1'b1;
                    stall_data = axi.s_rdata;
                end
            end
            if (freq_wr) begin
                if (exp_f_q.size() == 0) begin
                    check_val("strobe_unexpected", exp_f_q.size(), 1);
                end else begin
                    exp_f = exp_f_q.pop_front();
                    check_val("strobe_payload", {4'd0, symb, freq, cum}, {4'd0, exp_f});
                end
            end
            if (restart) restart_cnt++;
        end
    end

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int n = 0;
        axi.s_awaddr  = addr;
        axi.s_wdata   = data;
        axi.s_wstrb   = strb;
        axi.s_wvalid  = 1'b1;
        axi.s_awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && n < 200) begin
            @(negedge clk);
            if (w_lead > 0 && !axi.s_awvalid) begin
                check_val("no_early_b", {31'd0, axi.s_bvalid}, 32'd0);
                check_val("no_early_strobe", {31'd0, freq_wr}, 32'd0);
            end
            if (axi.s_awvalid && axi.s_awready) aw_done = 1'b1;
            if (axi.s_wvalid && axi.s_wready)   w_done  = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (aw_done) axi.s_awvalid = 1'b0;
            if (w_done)  axi.s_wvalid  = 1'b0;
            if (!aw_done && n >= w_lead) axi.s_awvalid = 1'b1;
        end
        axi.s_awvalid = 1'b0;
        axi.s_wvalid  = 1'b0;
        check_val("write_hs", {31'd0, aw_done && w_done}, 32'd1);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int lead, input logic [1:0] resp, input bit strobe);
        exp_b_q.push_back(resp);
        if (strobe) exp_f_q.push_back({addr[9:2], data[19:10], data[9:0]});
        axi_write(addr, data, strb, lead);
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit done = 1'b0;
        int n = 0;
        exp_r_q.push_back({data, resp});
        axi.s_araddr  = addr;
        axi.s_arvalid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (axi.s_arready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        axi.s_arvalid = 1'b0;
        check_val("read_hs", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b_q.size() + exp_r_q.size() + exp_f_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_b_q.size() + exp_r_q.size() + exp_f_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        axi.s_awaddr  = '0;
        axi.s_awvalid = 1'b0;
        axi.s_wdata   = 32'd0;
        axi.s_wstrb   = 4'd0;
        axi.s_wvalid  = 1'b0;
        axi.s_bready  = 1'b1;
        axi.s_araddr  = '0;
        axi.s_arvalid = 1'b0;
        eng_ready = 1'b1;
        sym_valid = 1'b0;
        sym_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_val("rst_awready", {31'd0, axi.s_awready}, 32'd1);
        check_val("rst_wready", {31'd0, axi.s_wready}, 32'd1);
        check_val("rst_arready", {31'd0, axi.s_arready}, 32'd1);
        check_val("rst_valids", {30'd0, axi.s_bvalid, axi.s_rvalid}, 32'd0);
        check_val("rst_strobes", {30'd0, freq_wr, restart}, 32'd0);
        check_val("rst_resps", {28'd0, axi.s_bresp, axi.s_rresp}, 32'd0);
        check_val("rst_rdata", axi.s_rdata, 32'd0);
        check_val("rst_payload", {4'd0, symb, freq, cum}, 32'd0);
        @(posedge clk);
        #1;
        rd(A_COUNT, 32'd0, RESP_OKAY);
        rd(A_SCRATCH, 32'd0, RESP_OKAY);
        rd(A_STATUS, 32'h1, RESP_OKAY);
        drain();

        // Basic FREQ write with latency probes, then readback.
        wr(11'h104, 32'h0002_8010, 4'hF, 0, RESP_OKAY, 1'b1);
        @(negedge clk);
        check_val("lat_fire_strobe", {31'd0, freq_wr}, 32'd0);
        check_val("lat_fire_b", {31'd0, axi.s_bvalid}, 32'd0);
        @(negedge clk);
        check_val("lat_strobe", {31'd0, freq_wr}, 32'd1);
        check_val("lat_b", {31'd0, axi.s_bvalid}, 32'd1);
        @(negedge clk);
        check_val("strobe_1cycle", {31'd0, freq_wr}, 32'd0);
        drain();
        rd(11'h104, 32'h0002_8010, RESP_OKAY);
        drain();

        // W leads AW by three cycles.
        wr(11'h014, 32'h0000_8030, 4'hF, 3, RESP_OKAY, 1'b1);
        drain();
        rd(11'h014, 32'h0000_8030, RESP_OKAY);
        drain();

        // Validation and sticky error.
        wr(11'h108, 32'h000C_0200, 4'hF, 0, RESP_SLVERR, 1'b0);
        drain();
        rd(A_STATUS, 32'h3, RESP_OKAY);
        drain();
        wr(A_CTRL, 32'h2, 4'hF, 0, RESP_OKAY, 1'b0);
        drain();
        rd(A_STATUS, 32'h1, RESP_OKAY);
        wr(11'h3FC, 32'h000F_C010, 4'hF, 0, RESP_OKAY, 1'b1);
        drain();
        wr(11'h3FC, 32'h0010_0001, 4'hF, 0, RESP_SLVERR, 1'b0);
        wr(A_SCRATCH, 32'h1234_5678, 4'hF, 0, RESP_OKAY, 1'b0);
        wr(A_SCRATCH, 32'h0000_5555, 4'h3, 0, RESP_SLVERR, 1'b0);
        wr(A_STATUS, 32'h1, 4'hF, 0, RESP_SLVERR, 1'b0);
        drain();
        rd(11'h3FC, 32'h000F_C010, RESP_OKAY);
        rd(A_SCRATCH, 32'h1234_5678, RESP_OKAY);
        rd(A_CTRL, 32'd0, RESP_OKAY);
        rd(A_STATUS, 32'h3, RESP_OKAY);
        drain();
        wr(A_CTRL, 32'h2, 4'hF, 0, RESP_OKAY, 1'b0);
        drain();

        // Symbol counter: five handshakes, then a restart coinciding with a sixth.
        for (int i = 0; i < 8; i++) begin
            sym_valid = (i != 2) && (i != 7);
            sym_ready = (i != 3);
            @(posedge clk);
            #1;
        end
        sym_valid = 1'b0;
        sym_ready = 1'b0;
        rd(A_COUNT, 32'd5, RESP_OKAY);
        drain();
        r0 = restart_cnt;
        wr(A_CTRL, 32'h1, 4'hF, 0, RESP_OKAY, 1'b0);
        sym_valid = 1'b1;
        sym_ready = 1'b1;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_ready = 1'b0;
        drain();
        check_val("restart_pulses", restart_cnt - r0, 1);
        rd(A_COUNT, 32'd0, RESP_OKAY);
        drain();

        // Engine stall with a pending write and B backpressure.
        axi.s_bready = 1'b0;
        eng_ready = 1'b0;
        wr(A_SCRATCH, 32'hDEAD_BEEF, 4'hF, 0, RESP_OKAY, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_awready", {31'd0, axi.s_awready}, 32'd0);
            check_val("stall_wready", {31'd0, axi.s_wready}, 32'd0);
            check_val("stall_bvalid", {31'd0, axi.s_bvalid}, 32'd0);
        end
        @(posedge clk);
        #1;
        rd(A_SCRATCH, 32'h1234_5678, RESP_OKAY);
        repeat (3) @(negedge clk);
        check_val("stall_rsp_done", exp_r_q.size(), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("stall_awready", {31'd0, axi.s_awready}, 32'd0);
        end
        @(posedge clk);
        #1 eng_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("b_pending", {31'd0, axi.s_bvalid}, 32'd1);
        check_val("b_pending_q", exp_b_q.size(), 1);
        @(posedge clk);
        #1 axi.s_bready = 1'b1;
        drain();
        @(negedge clk);
        check_val("b_released", {31'd0, axi.s_bvalid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back reads under RREADY toggling.
        rready_tog = 1'b1;
        rd(11'h104, 32'h0002_8010, RESP_OKAY);
        rd(A_SCRATCH, 32'hDEAD_BEEF, RESP_OKAY);
        rd(A_BAD, 32'd0, RESP_SLVERR);
        drain();
        rready_tog = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd(A_STATUS, 32'h3, RESP_OKAY);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
